// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM arbiter: two read requesters (A has priority over B) and two write sources
// (the external loader and the internal clear engine) share one RAM with one read port
// and one write port.
// Optional B starvation guard: define SPRITE_ARB_STARVE_GUARD_EN.
module sprite_ram_arbiter #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 3,
  parameter int unsigned       DEPTH     = 400,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
`ifdef SPRITE_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned       STARVE_MAX = 8
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              rdA_req,
  input  logic [ADDR_W-1:0] rdA_addr,
  output logic              rdA_gnt,
  output logic              rdA_valid,
  output logic [DATA_W-1:0] rdA_data,
  input  logic              rdB_req,
  input  logic [ADDR_W-1:0] rdB_addr,
  output logic              rdB_gnt,
  output logic              rdB_valid,
  output logic [DATA_W-1:0] rdB_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_In,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_Out
);

  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_done_q, clr_done_d;
  logic              a_valid_q, b_valid_q, oor_q;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;
  logic [DATA_W-1:0] ret_data;
  logic              rd_oor;
  logic              starve_force;

`ifdef SPRITE_ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic [StarveW-1:0] starve_q, starve_d;

  assign starve_force = (starve_q == StarveW'(STARVE_MAX));

  // Count consecutive cycles where B asks but loses; any B grant or idle B clears it.
  always_comb begin
    starve_d = starve_q;
    if (!rdB_req || rdB_gnt) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Read arbitration: A wins unless B is being forced through; grants are dead in reset.
  always_comb begin
    rdA_gnt = 1'b0;
    rdB_gnt = 1'b0;
    if (Reset_n) begin
      if (rdB_req && (starve_force || !rdA_req)) begin
        rdB_gnt = 1'b1;
      end else if (rdA_req) begin
        rdA_gnt = 1'b1;
      end
    end
    ram_read_address = rdB_gnt ? rdB_addr : rdA_addr;
    rd_oor           = ({1'b0, ram_read_address} >= DepthExt);
  end

  // Read return tag and per-requester data hold registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      oor_q     <= 1'b0;
      a_hold_q  <= '0;
      b_hold_q  <= '0;
    end else begin
      a_valid_q <= rdA_gnt;
      b_valid_q <= rdB_gnt;
      oor_q     <= rd_oor;
      if (a_valid_q) a_hold_q <= ret_data;
      if (b_valid_q) b_hold_q <= ret_data;
    end
  end

  // Return data: RAM output for the winner, zero for out-of-range, hold otherwise.
  always_comb begin
    ret_data  = oor_q ? '0 : ram_data_Out;
    rdA_valid = a_valid_q;
    rdB_valid = b_valid_q;
    rdA_data  = a_valid_q ? ret_data : a_hold_q;
    rdB_data  = b_valid_q ? ret_data : b_hold_q;
  end

  // Write port ownership: loader in idle, clear engine sweeps all addresses in clear.
  always_comb begin
    state_d           = state_q;
    clr_cnt_d         = clr_cnt_q;
    clr_done_d        = 1'b0;
    wr_gnt            = 1'b0;
    ram_we            = 1'b0;
    ram_write_address = wr_addr;
    ram_data_In       = wr_data;
    clr_busy          = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_gnt = wr_req && Reset_n;
        // Out-of-range writes are accepted but never reach the RAM.
        ram_we = wr_gnt && ({1'b0, wr_addr} < DepthExt);
        if (clr_start) state_d = StClear;
      end
      StClear: begin
        clr_busy          = 1'b1;
        ram_we            = 1'b1;
        ram_write_address = clr_cnt_q;
        ram_data_In       = CLEAR_VAL;
        if (clr_cnt_q == LastAddr) begin
          state_d    = StIdle;
          clr_cnt_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM state, address counter and done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Self-checking bench for sprite_ram_arbiter: table of single-cycle vectors plus hand-written
// sequences for starvation, full clear and reset mid-clear. Read returns go through a queue.
module tb_sprite_ram_arbiter;

`ifdef SPRITE_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       rdA_req, rdB_req, wr_req, clr_start;
  logic [9:0] rdA_addr, rdB_addr, wr_addr;
  logic [2:0] wr_data;
  logic       rdA_gnt, rdA_valid, rdB_gnt, rdB_valid, wr_gnt, clr_busy, clr_done, ram_we;
  logic [2:0] rdA_data, rdB_data, ram_data_In, ram_data_Out;
  logic [9:0] ram_read_address, ram_write_address;

  sprite_ram_arbiter dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .rdA_req           (rdA_req),
    .rdA_addr          (rdA_addr),
    .rdA_gnt           (rdA_gnt),
    .rdA_valid         (rdA_valid),
    .rdA_data          (rdA_data),
    .rdB_req           (rdB_req),
    .rdB_addr          (rdB_addr),
    .rdB_gnt           (rdB_gnt),
    .rdB_valid         (rdB_valid),
    .rdB_data          (rdB_data),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_gnt            (wr_gnt),
    .clr_start         (clr_start),
    .clr_busy          (clr_busy),
    .clr_done          (clr_done),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_data_In       (ram_data_In),
    .ram_we            (ram_we),
    .ram_data_Out      (ram_data_Out)
  );

  always #5 Clk = ~Clk;

  // Sprite RAM: registered read, read-before-write; init_en loads a known pattern.
  logic       init_en = 1'b0;
  logic [2:0] mem [0:1023];
  always @(posedge Clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 3'(i % 8);
    end else if (ram_we) begin
      mem[ram_write_address] <= ram_data_In;
    end
    ram_data_Out <= mem[ram_read_address];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [2:0] shadow [0:399];

  typedef struct {
    int         due;
    bit         port;  // 0 = A, 1 = B
    logic [2:0] data;
  } sb_t;
  sb_t sb [$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_read(input bit port, input logic [9:0] addr);
    sb_t it;
    it.due  = cyc + 1;
    it.port = port;
    it.data = (addr >= 10'd400) ? 3'd0 : shadow[addr];
    sb.push_back(it);
  endtask

  // Scoreboard consumer: each granted read must return exactly one cycle later.
  logic [2:0] last_a = 3'd0;
  logic [2:0] last_b = 3'd0;
  always @(negedge Clk) begin
    sb_t e;
    if (Reset_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rd_valid", {30'd0, rdA_valid, rdB_valid}, e.port ? 32'd1 : 32'd2);
        if (e.port) begin
          chk("rdB_data", rdB_data, e.data);
          chk("rdA_hold", rdA_data, last_a);
          last_b = e.data;
        end else begin
          chk("rdA_data", rdA_data, e.data);
          chk("rdB_hold", rdB_data, last_b);
          last_a = e.data;
        end
      end else if (rdA_valid || rdB_valid) begin
        chk("rd_spurious", {30'd0, rdA_valid, rdB_valid}, 32'd0);
      end
    end else begin
      last_a = 3'd0;
      last_b = 3'd0;
    end
  end

  typedef struct {
    logic       a_req;
    logic [9:0] a_addr;
    logic       b_req;
    logic [9:0] b_addr;
    logic       w_req;
    logic [9:0] w_addr;
    logic [2:0] w_data;
    logic       e_ga, e_gb, e_wg, e_we;
    logic [9:0] e_raddr;
  } vec_t;

  function automatic vec_t mk(input logic ar, input int aa, input logic br, input int ba,
                              input logic wr, input int wa, input int wd, input logic ga,
                              input logic gb, input logic wg, input logic we, input int ra);
    vec_t v;
    v.a_req = ar; v.a_addr = 10'(aa); v.b_req = br; v.b_addr = 10'(ba);
    v.w_req = wr; v.w_addr = 10'(wa); v.w_data = 3'(wd);
    v.e_ga = ga; v.e_gb = gb; v.e_wg = wg; v.e_we = we; v.e_raddr = 10'(ra);
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdA_req = 0; rdA_addr = 0; rdB_req = 0; rdB_addr = 0;
    wr_req = 0; wr_addr = 0; wr_data = 0; clr_start = 0;
  endtask

  // One-cycle read on the given port with no competition.
  task automatic do_read(input bit port, input logic [9:0] addr);
    next_cycle();
    idle_inputs();
    if (port) begin rdB_req = 1; rdB_addr = addr; end
    else begin rdA_req = 1; rdA_addr = addr; end
    @(negedge Clk);
    chk(port ? "rd_gntB" : "rd_gntA", port ? rdB_gnt : rdA_gnt, 1);
    push_read(port, addr);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  vec_t vecs [12];

  initial begin
    int busy_n, done_n, wg_busy, last_busy, done_at;

    vecs[0]  = mk(0, 0,   0, 0,   1, 5,   3, 0, 0, 1, 1, 0);
    vecs[1]  = mk(1, 5,   0, 0,   0, 0,   0, 1, 0, 0, 0, 5);
    vecs[2]  = mk(0, 0,   0, 0,   1, 10,  6, 0, 0, 1, 1, 0);
    vecs[3]  = mk(0, 0,   1, 10,  0, 0,   0, 0, 1, 0, 0, 10);
    vecs[4]  = mk(1, 400, 0, 0,   1, 512, 1, 1, 0, 1, 0, 400);
    vecs[5]  = mk(1, 7,   1, 9,   0, 0,   0, 1, 0, 0, 0, 7);
    vecs[6]  = mk(0, 7,   1, 9,   0, 0,   0, 0, 1, 0, 0, 9);
    vecs[7]  = mk(1, 20,  0, 0,   1, 20,  2, 1, 0, 1, 1, 20);
    vecs[8]  = mk(1, 20,  0, 0,   0, 0,   0, 1, 0, 0, 0, 20);
    vecs[9]  = mk(0, 33,  0, 44,  0, 0,   0, 0, 0, 0, 0, 33);
    vecs[10] = mk(0, 0,   0, 0,   1, 399, 5, 0, 0, 1, 1, 0);
    vecs[11] = mk(0, 0,   1, 399, 1, 400, 7, 0, 1, 1, 0, 399);

    for (int i = 0; i < 400; i++) shadow[i] = 3'(i % 8);

    // Reset with requests active: everything must stay quiet.
    idle_inputs();
    Reset_n = 0; init_en = 1;
    rdA_req = 1; rdB_req = 1; wr_req = 1; wr_addr = 5;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_gnt", {29'd0, rdA_gnt, rdB_gnt, wr_gnt}, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_valid", {30'd0, rdA_valid, rdB_valid}, 0);
    chk("rst_data", {26'd0, rdA_data, rdB_data}, 0);
    chk("rst_clr", {30'd0, clr_busy, clr_done}, 0);
    next_cycle();
    idle_inputs();
    init_en = 0;
    Reset_n = 1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      rdA_req = vecs[i].a_req; rdA_addr = vecs[i].a_addr;
      rdB_req = vecs[i].b_req; rdB_addr = vecs[i].b_addr;
      wr_req  = vecs[i].w_req; wr_addr  = vecs[i].w_addr; wr_data = vecs[i].w_data;
      @(negedge Clk);
      chk($sformatf("v%0d_gntA", i), rdA_gnt, vecs[i].e_ga);
      chk($sformatf("v%0d_gntB", i), rdB_gnt, vecs[i].e_gb);
      chk($sformatf("v%0d_raddr", i), ram_read_address, vecs[i].e_raddr);
      chk($sformatf("v%0d_wgnt", i), wr_gnt, vecs[i].e_wg);
      chk($sformatf("v%0d_we", i), ram_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), ram_write_address, vecs[i].w_addr);
        chk($sformatf("v%0d_wdata", i), ram_data_In, vecs[i].w_data);
      end
      if (vecs[i].e_ga) push_read(0, vecs[i].a_addr);
      if (vecs[i].e_gb) push_read(1, vecs[i].b_addr);
      if (vecs[i].w_req && vecs[i].w_addr < 10'd400) shadow[vecs[i].w_addr] = vecs[i].w_data;
    end
    next_cycle();
    idle_inputs();

    // A and B both requesting for 12 cycles.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      rdA_req = 1; rdA_addr = 1; rdB_req = 1; rdB_addr = 2;
      @(negedge Clk);
      chk($sformatf("starve%0d_gntA", i), rdA_gnt, !(Guard && i == 8));
      chk($sformatf("starve%0d_gntB", i), rdB_gnt, Guard && i == 8);
      if (rdB_gnt) push_read(1, 2);
      else if (rdA_gnt) push_read(0, 1);
    end
    next_cycle();
    idle_inputs();

    // Full clear with the loader hammering (out-of-range so post-clear writes are dropped).
    next_cycle();
    clr_start = 1; wr_req = 1; wr_addr = 512; wr_data = 7;
    @(negedge Clk);
    chk("clr_start_wgnt", wr_gnt, 1);
    chk("clr_start_busy", clr_busy, 0);
    busy_n = 0; done_n = 0; wg_busy = 0; last_busy = -1; done_at = -1;
    for (int i = 0; i < 420; i++) begin
      next_cycle();
      clr_start = (i == 200);
      @(negedge Clk);
      if (clr_busy) begin
        busy_n++;
        last_busy = i;
        if (wr_gnt) wg_busy++;
      end
      if (clr_done) begin
        done_n++;
        done_at = i;
      end
    end
    chk("clr_busy_cycles", busy_n, 400);
    chk("clr_wgnt_busy", wg_busy, 0);
    chk("clr_done_pulses", done_n, 1);
    chk("clr_done_timing", done_at, last_busy + 1);
    for (int i = 0; i < 400; i++) shadow[i] = 3'd0;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 400; i++) do_read(0, 10'(i));
    next_cycle();
    idle_inputs();

    // Reset in the middle of a clear.
    next_cycle();
    wr_req = 1; wr_addr = 150; wr_data = 5;
    shadow[150] = 3'd5;
    next_cycle();
    idle_inputs();
    clr_start = 1;
    next_cycle();
    clr_start = 0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (clr_busy) busy_n++;
      next_cycle();
    end
    chk("midclr_busy", busy_n, 100);
    Reset_n = 0; rdA_req = 1; wr_req = 1; wr_addr = 150; wr_data = 1;
    #1;
    chk("midclr_rst_busy", clr_busy, 0);
    chk("midclr_rst_we", ram_we, 0);
    chk("midclr_rst_gnt", {30'd0, rdA_gnt, wr_gnt}, 0);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (clr_done) done_n++;
    end
    next_cycle();
    idle_inputs();
    Reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (clr_done || clr_busy) done_n++;
    end
    chk("midclr_no_done", done_n, 0);
    do_read(0, 150);
    do_read(1, 150);
    do_read(0, 399);
    next_cycle();
    idle_inputs();
    repeat (3) @(negedge Clk);
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
